// File: rtl/lf_pkg.sv
// lf_pkg: shared types and helpers for the Ladner-Fischer prefix datapath.
//   pg_t        : propagate/generate pair for one bit or one group span
//   lf_combine  : prefix operator; merges a high span with the span below it
//   clog2       : prefix depth of an operand width
//   s1_levels   : prefix levels evaluated ahead of the first pipeline register
package lf_pkg;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  // The high span passes the low span's generate through only if it
  // propagates across its whole width.
  function automatic pg_t lf_combine(pg_t hi, pg_t lo);
    pg_t r;
    r.p = hi.p & lo.p;
    r.g = hi.g | (hi.p & lo.g);
    return r;
  endfunction

  function automatic int clog2(int v);
    int r;
    r = 32'sd0;
    while ((32'sd1 <<< r) < v) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

  // WIDTH/8 clipped to [1, depth-1] so both pipeline stages hold at least
  // one prefix level.
  function automatic int s1_levels(int width);
    int depth;
    int s;
    depth = clog2(width);
    s     = width / 32'sd8;
    if (s < 32'sd1) begin
      s = 32'sd1;
    end else if (s > depth - 32'sd1) begin
      s = depth - 32'sd1;
    end else begin
      s = s;
    end
    return s;
  endfunction

endpackage

// File: rtl/lf_prefix_levels.sv
// lf_prefix_levels: combinational slice of a Ladner-Fischer prefix network.
// Evaluates NUM_LEVELS consecutive levels starting at FIRST_LEVEL, so a full
// network can be cut anywhere for pipelining.
//   p_in/g_in   : group propagate/generate entering the slice
//   p_out/g_out : group propagate/generate leaving the slice
// At level k, every bit whose index has bit k set sits in an odd block of
// size 2^k and combines with the prefix ending just below that block.
module lf_prefix_levels
  import lf_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int FIRST_LEVEL = 0,
  parameter int NUM_LEVELS  = 1
) (
  input  logic [WIDTH-1:0] p_in,
  input  logic [WIDTH-1:0] g_in,
  output logic [WIDTH-1:0] p_out,
  output logic [WIDTH-1:0] g_out
);

  for (genvar l = 0; l < NUM_LEVELS; l++) begin : g_lvl
    localparam int K = FIRST_LEVEL + l;

    logic [WIDTH-1:0] p_prev_s;
    logic [WIDTH-1:0] g_prev_s;
    logic [WIDTH-1:0] p_s;
    logic [WIDTH-1:0] g_s;

    if (l == 0) begin : g_first
      assign p_prev_s = p_in;
      assign g_prev_s = g_in;
    end else begin : g_chain
      assign p_prev_s = g_lvl[l-1].p_s;
      assign g_prev_s = g_lvl[l-1].g_s;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (((i >> K) % 32'sd2) == 32'sd1) begin : g_cmb
        // Last bit of the preceding block of size 2^K.
        localparam int J = ((i >> K) << K) - 32'sd1;
        pg_t r_s;
        assign r_s    = lf_combine({p_prev_s[i], g_prev_s[i]},
                                   {p_prev_s[J], g_prev_s[J]});
        assign p_s[i] = r_s.p;
        assign g_s[i] = r_s.g;
      end else begin : g_pass
        assign p_s[i] = p_prev_s[i];
        assign g_s[i] = g_prev_s[i];
      end
    end
  end

  assign p_out = g_lvl[NUM_LEVELS-1].p_s;
  assign g_out = g_lvl[NUM_LEVELS-1].g_s;

endmodule

// File: rtl/lf16_sub_pipe.sv
// lf16_sub_pipe: two-stage pipelined subtractor, diff = a - b - bin, built on
// a Ladner-Fischer prefix carry network with a valid/ready stall pipeline.
//   clk, rst              : clock and synchronous active-high reset
//   in_valid/in_ready     : operand handshake (a, b, bin)
//   out_valid/out_ready   : result handshake (diff, bout, zero, ovf)
//   diff                  : a - b - bin modulo 2^WIDTH
//   bout                  : borrow out, set when a < b + bin (unsigned)
//   zero                  : diff is all zeros
//   ovf                   : two's-complement overflow of the subtraction
// Subtraction is evaluated as a + ~b + ~bin. The carry-in is folded into
// bit 0 as the generate of a virtual bit below it, so the group generate
// ending at bit i is the carry into bit i+1.
module lf16_sub_pipe
  import lf_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int S1_LEVELS = s1_levels(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int L         = clog2(WIDTH);
  localparam int S2_LEVELS = L - S1_LEVELS;

  // Handshake
  logic adv1_s;
  logic adv2_s;
  logic s1_valid_r;
  logic s2_valid_r;

  // Stage 0 (combinational, ahead of the S1 register)
  logic [WIDTH-1:0] p0_s;
  logic [WIDTH-1:0] g0_s;
  logic [WIDTH-1:0] pf_s;
  logic [WIDTH-1:0] gf_s;
  logic [WIDTH-1:0] gp1_s;
  logic [WIDTH-1:0] gg1_s;
  logic             cin_s;
  pg_t              bit0_s;

  // Stage 1 registers
  logic [WIDTH-1:0] p_r;
  logic [WIDTH-1:0] gp_r;
  logic [WIDTH-1:0] gg_r;
  logic             cin_r;
  logic             sa_r;
  logic             sb_r;

  // Stage 2 combinational
  logic [WIDTH-1:0] unused_gp2_s;
  logic [WIDTH-1:0] gg2_s;
  logic [WIDTH-1:0] carry_s;
  logic [WIDTH-1:0] diff_s;
  logic             bout_s;
  logic             zero_s;
  logic             ovf_s;

  // Stage 2 registers
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             zero_r;
  logic             ovf_r;

  assign adv2_s   = ~s2_valid_r | out_ready;
  assign adv1_s   = ~s1_valid_r | adv2_s;
  assign in_ready = adv1_s;

  assign cin_s = ~bin;
  assign p0_s  = a ^ ~b;
  assign g0_s  = a & ~b;

  // Virtual bit -1 has p=0, g=cin; merging it into bit 0 leaves the whole
  // network free of a separate carry-in column.
  assign bit0_s = lf_combine({p0_s[0], g0_s[0]}, {1'b0, cin_s});
  assign pf_s   = {p0_s[WIDTH-1:1], bit0_s.p};
  assign gf_s   = {g0_s[WIDTH-1:1], bit0_s.g};

  lf_prefix_levels #(
    .WIDTH      (WIDTH),
    .FIRST_LEVEL(0),
    .NUM_LEVELS (S1_LEVELS)
  ) u_prefix_s1 (
    .p_in (pf_s),
    .g_in (gf_s),
    .p_out(gp1_s),
    .g_out(gg1_s)
  );

  // Stage 1 register: partial prefix, raw propagate for the sum, operand signs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      p_r        <= {WIDTH{1'b0}};
      gp_r       <= {WIDTH{1'b0}};
      gg_r       <= {WIDTH{1'b0}};
      cin_r      <= 1'b0;
      sa_r       <= 1'b0;
      sb_r       <= 1'b0;
    end else if (adv1_s) begin
      s1_valid_r <= in_valid;
      p_r        <= p0_s;
      gp_r       <= gp1_s;
      gg_r       <= gg1_s;
      cin_r      <= cin_s;
      sa_r       <= a[WIDTH-1];
      sb_r       <= b[WIDTH-1];
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  lf_prefix_levels #(
    .WIDTH      (WIDTH),
    .FIRST_LEVEL(S1_LEVELS),
    .NUM_LEVELS (S2_LEVELS)
  ) u_prefix_s2 (
    .p_in (gp_r),
    .g_in (gg_r),
    .p_out(unused_gp2_s),
    .g_out(gg2_s)
  );

  // Group generate ending at bit i-1 is the carry into bit i.
  assign carry_s = {gg2_s[WIDTH-2:0], cin_r};
  assign diff_s  = p_r ^ carry_s;
  assign bout_s  = ~gg2_s[WIDTH-1];
  assign zero_s  = (diff_s == {WIDTH{1'b0}});
  assign ovf_s   = (sa_r ^ sb_r) & (diff_s[WIDTH-1] ^ sa_r);

  // Stage 2 register: final result and flags; holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      diff_r     <= {WIDTH{1'b0}};
      bout_r     <= 1'b0;
      zero_r     <= 1'b0;
      ovf_r      <= 1'b0;
    end else if (adv2_s) begin
      s2_valid_r <= s1_valid_r;
      diff_r     <= diff_s;
      bout_r     <= bout_s;
      zero_r     <= zero_s;
      ovf_r      <= ovf_s;
    end else begin
      s2_valid_r <= s2_valid_r;
    end
  end

  assign out_valid = s2_valid_r;
  assign diff      = diff_r;
  assign bout      = bout_r;
  assign zero      = zero_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_lf16_sub_pipe.sv
// Scoreboard bench for lf16_sub_pipe: the driver pushes the expected result
// when a beat is accepted; a monitor pops and compares on every output
// handshake. Inputs change 1 time unit after the rising edge; handshakes and
// outputs are sampled on the falling edge.
module tb_lf16_sub_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         zero;
  logic         ovf;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
    logic         ovf;
    int           cyc;
  } exp_t;

  exp_t sb_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit lat_chk    = 1'b0;
  bit stream_chk = 1'b0;

  bit           held = 1'b0;
  logic [W-1:0] held_diff;
  logic         held_bout;
  logic         held_zero;
  logic         held_ovf;

  lf16_sub_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout),
    .zero     (zero),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Present one beat (caller sits just after a rising edge) and push the
  // expected result on the falling edge before the edge that accepts it.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic tbin, input logic [W-1:0] ediff,
                      input logic ebout, input logic ezero, input logic eovf);
    exp_t e;
    bit   done;
    done     = 1'b0;
    a        = ta;
    b        = tb;
    bin      = tbin;
    in_valid = 1'b1;
    for (int w = 0; w < 50 && !done; w++) begin
      @(negedge clk);
      if (in_ready) begin
        e.diff = ediff;
        e.bout = ebout;
        e.zero = ezero;
        e.ovf  = eovf;
        e.cyc  = cyc;
        sb_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  // Reference model for random beats: 17-bit difference gives the borrow.
  task automatic send_model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
    logic [W:0] full;
    logic       o;
    full = {1'b0, ta} - {1'b0, tb} - {{W{1'b0}}, tbin};
    o    = (ta[W-1] != tb[W-1]) && (full[W-1] != ta[W-1]);
    send(ta, tb, tbin, full[W-1:0], full[W], (full[W-1:0] == 16'h0000), o);
  endtask

  task automatic drain();
    for (int w = 0; w < 40 && sb_q.size() != 0; w++) @(posedge clk);
    #1;
    check("drain_empty", sb_q.size(), 32'd0);
  endtask

  // Monitor: pop on output handshakes, check stability while stalled.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      held = 1'b0;
    end else begin
      if (stream_chk) check("in_ready_stream", in_ready, 32'd1);
      if (out_valid && !out_ready) begin
        if (held) begin
          check("hold_diff", diff, held_diff);
          check("hold_bout", bout, held_bout);
          check("hold_zero", zero, held_zero);
          check("hold_ovf", ovf, held_ovf);
        end
        held      = 1'b1;
        held_diff = diff;
        held_bout = bout;
        held_zero = zero;
        held_ovf  = ovf;
      end else begin
        held = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("diff", diff, e.diff);
          check("bout", bout, e.bout);
          check("zero", zero, e.zero);
          check("ovf", ovf, e.ovf);
          if (lat_chk) check("latency", cyc - e.cyc, 32'd2);
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = 16'h0000;
    b         = 16'h0000;
    bin       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_diff", diff, 32'd0);
    check("rst_bout", bout, 32'd0);
    check("rst_zero", zero, 32'd0);
    check("rst_ovf", ovf, 32'd0);
    check("rst_in_ready", in_ready, 32'd1);
    @(posedge clk);
    #1;

    // Directed vectors with hand-computed results
    lat_chk = 1'b1;
    send(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    send(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    send(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1);
    send(16'h00FF, 16'h00FE, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
    send(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    send(16'h5A5A, 16'h5A5A, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    send(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1);
    send(16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    send(16'h8000, 16'h8000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    drain();

    // Back-to-back random stream
    stream_chk = 1'b1;
    for (int i = 0; i < 100; i++) begin
      send_model(16'($urandom()), 16'($urandom()), 1'($urandom_range(1, 0)));
    end
    drain();
    stream_chk = 1'b0;

    // Stall: three beats with out_ready low, then release
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    send(16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0);
    send(16'h0001, 16'h0002, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("stall_in_ready", in_ready, 32'd0);
    check("stall_out_valid", out_valid, 32'd1);
    @(posedge clk);
    #1;
    fork
      send(16'hC000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0);
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight
    lat_chk = 1'b1;
    send(16'h1111, 16'h0001, 1'b0, 16'h1110, 1'b0, 1'b0, 1'b0);
    send(16'h2222, 16'h0002, 1'b0, 16'h2220, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst2_out_valid", out_valid, 32'd0);
    check("rst2_diff", diff, 32'd0);
    check("rst2_in_ready", in_ready, 32'd1);
    @(posedge clk);
    #1;
    send(16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
